// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The master drives the controls; the slave supplies the opcode and memory ready.
interface multicycle_controller_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       HalfWord;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg, HalfWord,
           ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_op, state
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg, HalfWord,
           ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for a shared-memory datapath (RTYPE/LW/SW/ADDI/LH),
// with a memory ready handshake that can stall fetch, load and store.
module multicycle_controller #(
  parameter bit WAIT_MEM = 1'b1
) (
  input logic                          clk,
  input logic                          reset,
  multicycle_controller_if.master      bus
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLh    = 6'b100001;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StAddiExec = 4'd8,
    StAddiWb   = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       ready;

  assign ready = WAIT_MEM ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    case (state_q)
      StFetch:    if (ready) state_d = StDecode;
      StDecode: begin
        op_d = bus.op;
        case (bus.op)
          OpLw, OpSw, OpLh: state_d = StMemAdr;
          OpRtype:          state_d = StExecute;
          OpAddi:           state_d = StAddiExec;
          default: begin
            illegal_d = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMemAdr:   state_d = (op_q == OpSw) ? StMemWrite : StMemRead;
      StMemRead:  if (ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (ready) state_d = StFetch;
      StExecute:  state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StAddiExec: state_d = StAddiWb;
      StAddiWb:   state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // Reset forces every control low so an abandoned instruction cannot strobe.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.HalfWord   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUOp      = 2'b00;
    bus.instr_done = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          bus.mem_req = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = ready;
          bus.PCWrite = ready;
        end
        StDecode: begin
          bus.ALUSrcB = 2'b11;
          case (bus.op)
            OpLw, OpSw, OpLh, OpRtype, OpAddi: bus.instr_done = 1'b0;
            default:                           bus.instr_done = 1'b1;
          endcase
        end
        StMemAdr: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        StMemRead: begin
          bus.mem_req  = 1'b1;
          bus.IorD     = 1'b1;
          bus.HalfWord = (op_q == OpLh);
        end
        StMemWb: begin
          bus.RegWrite   = 1'b1;
          bus.MemtoReg   = 1'b1;
          bus.HalfWord   = (op_q == OpLh);
          bus.instr_done = 1'b1;
        end
        StMemWrite: begin
          bus.mem_req    = 1'b1;
          bus.IorD       = 1'b1;
          bus.MemWrite   = 1'b1;
          bus.instr_done = ready;
        end
        StExecute: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = 2'b10;
        end
        StAluWb: begin
          bus.RegWrite   = 1'b1;
          bus.RegDst     = 1'b1;
          bus.instr_done = 1'b1;
        end
        StAddiExec: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        StAddiWb: begin
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.illegal_op = illegal_q;
  assign bus.state      = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle control FSM sequencing the shared datapath (one memory, one ALU, register file) over several cycles per instruction.
- Supports RTYPE (000000), LW (100011), SW (101011), ADDI (001000) and LH (100001) with the same ALUOp/HalfWord semantics as the existing single-cycle decoder.
- Adds a memory ready handshake so slow memory can stall fetch, load and store.
- Sits between the instruction register (op field) and the datapath mux, enable and strobe controls.

Parameters:
- WAIT_MEM, 1, 1 = honour mem_ready; 0 = treat mem_ready as permanently 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  opcode from IR[31:26]; valid from the DECODE state onward.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory access request.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load enable.
- PCWrite  output  1  PC load enable (PC+4).
- RegWrite  output  1  register file write enable.
- RegDst  output  1  destination register select: 1 = rd, 0 = rt.
- MemtoReg  output  1  write-back select: 1 = MDR, 0 = ALUOut.
- HalfWord  output  1  halfword load select for the MDR path.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  output  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- ALUOp  output  2  00 = add, 10 = funct-decoded.
- instr_done  output  1  one-cycle pulse in the last cycle of each instruction.
- illegal_op  output  1  sticky flag: an unsupported opcode was decoded.
- state  output  4  current state encoding, for debug.

Behaviour:
- Reset (synchronous): state <= FETCH, op_q <= 0, illegal_op <= 0.
- In any cycle where reset=1, all combinational outputs are 0. Reset mid-instruction abandons it: no write strobe fires after reset is sampled.
- Outputs are decoded from state, with mem_ready gating where noted. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - If mem_ready: IRWrite=1, PCWrite=1, next DECODE. Otherwise hold FETCH with IRWrite=PCWrite=0.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - op_q <= op.
  - Next state: LW/SW/LH -> MEMADR; RTYPE -> EXECUTE; ADDI -> ADDIEXEC.
  - Any other op: illegal_op <= 1, instr_done=1, next FETCH.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: op_q SW -> MEMWRITE; LW/LH -> MEMREAD.
- MEMREAD:
  - Outputs: mem_req=1, IorD=1, HalfWord=(op_q==LH).
  - Hold until mem_ready, then next MEMWB.
- MEMWB:
  - Outputs: RegWrite=1, RegDst=0, MemtoReg=1, HalfWord=(op_q==LH), instr_done=1.
  - Next FETCH.
- MEMWRITE:
  - Outputs: mem_req=1, IorD=1, MemWrite=1. MemWrite is held for the whole wait.
  - If mem_ready: instr_done=1, next FETCH.
- EXECUTE:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next ALUWB.
- ALUWB:
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1.
  - Next FETCH.
- ADDIEXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next ADDIWB.
- ADDIWB:
  - Outputs: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1.
  - Next FETCH.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, ADDIEXEC=8, ADDIWB=9.
  - Codes 10-15 are unreachable; if entered, next state is FETCH with all outputs 0.
- Latency with mem_ready=1 throughout:
  - 4 cycles: RTYPE, SW, ADDI.
  - 5 cycles: LW, LH.
  - 2 cycles: illegal opcode.
  - Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Mid-instruction op changes are ignored: op is sampled only in DECODE, and later states use op_q.
- Exactly one RegWrite cycle per register-writing instruction. PCWrite fires only in FETCH.

Test Plan:
- Reset: reset=1 for 2 cycles, then release with mem_ready=1 -> state=0, all strobes 0 during reset, illegal_op=0; first cycle after release shows mem_req=1, IRWrite=1, PCWrite=1.
- RTYPE: op=000000, mem_ready=1 -> states 0,1,6,7; in state 7 RegWrite=1, RegDst=1, ALUOp was 10 in state 6; instr_done pulses only in state 7.
- LH with stalls: op=100001, mem_ready low for 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4 (8 cycles); HalfWord=1 in states 3-4; MemtoReg=1 and RegWrite=1 in state 4.
- SW stall: op=101011, mem_ready=0 for 2 cycles in MEMWRITE -> MemWrite=1 for 3 consecutive cycles; RegWrite never 1; instr_done in the third.
- Illegal opcode: op=111111 -> DECODE back to FETCH in 2 cycles, illegal_op=1 and stays 1 through a following ADDI; the ADDI completes in 4 cycles with RegWrite in state 9.
- Reset mid-load: assert reset while in MEMREAD -> no RegWrite, next state FETCH, op_q=0; WAIT_MEM=0 variant with mem_ready=0 still completes LW in 5 cycles.
